spike_rate_encoder: RTL and testbench
=====================================

Name: spike_rate_encoder

Overview:
Converts NUM_CHANNELS stored pixel intensities into rate-coded spike trains over a fixed window of WINDOW_LEN cycles. It produces the per-cycle input spike vector for the SNN core's ui_in spike inputs. It is the encoding counterpart of the output spike counter: with the defaults, the spike count on each channel equals that channel's intensity exactly. A host loads intensities through a write port, pulses start, and waits for done.

Parameters:
NUM_CHANNELS, 8, number of intensity registers and spike outputs
WIDTH_P, 8, intensity and accumulator width
WINDOW_LEN, 256, number of spike slots per encoding window (1..2^16)
LFSR_SEED, 8'hA5, nonzero seed for the optional Poisson mode

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
wr_en_i  in  1  intensity write strobe
wr_addr_i  in  clog2(NUM_CHANNELS)  channel index
wr_data_i  in  WIDTH_P  intensity value
wr_ready_o  out  1  high when writes are accepted (IDLE or DONE)
start_i  in  1  begin encoding window
stop_i  in  1  abort window
spike_o  out  NUM_CHANNELS  registered spike vector, drives the SNN spike inputs
busy_o  out  1  high while in RUN
done_o  out  1  single-cycle pulse at window end

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- On reset:
  - state = IDLE; all intensities = 0; accumulators = 0; window counter = 0.
  - spike_o = 0, busy_o = 0, done_o = 0, wr_ready_o = 1.
- States: IDLE, RUN, DONE.
  - wr_ready_o = (state != RUN).
  - busy_o = (state == RUN).
- Writes:
  - When wr_en_i && wr_ready_o, intensity[wr_addr_i] <= wr_data_i at the edge.
  - Writes while in RUN are dropped.
  - wr_addr_i >= NUM_CHANNELS is ignored.
- Start:
  - start_i sampled in IDLE or DONE: next state RUN; accumulators = 0; counter = 0; spike_o = 0.
  - A write in the same cycle as start_i commits and is used by the first RUN edge.
  - start_i in RUN is ignored.
- RUN, at each edge, for each channel c:
  - sum = acc[c] + intensity[c], computed WIDTH_P+1 bits wide.
  - acc[c] <= sum[WIDTH_P-1:0].
  - spike_o[c] <= sum[WIDTH_P].
  - counter increments.
  - When counter == WINDOW_LEN-1 on that edge: next state DONE, done_o <= 1.
- Spike output timing:
  - spike_o holds slot k during the cycle after RUN edge k, so there are exactly WINDOW_LEN slots.
  - The final slot coincides with the done_o cycle.
  - Per-channel spike count = floor(I*WINDOW_LEN / 2^WIDTH_P).
  - With the defaults, count = I; I=0 never spikes and I=255 gives 255 spikes.
- DONE:
  - The edge after entry clears spike_o to 0 and done_o to 0.
  - The state holds in DONE until start_i.
  - Intensities are retained.
- stop_i in RUN: next state IDLE; spike_o <= 0; no done_o pulse. stop_i has priority over window completion on the same edge.
- stop_i outside RUN has no effect.
- Reset mid-RUN: all outputs go to their reset values immediately, with no done_o; intensities are lost.
- Counter width: clog2(WINDOW_LEN+1). The counter never wraps inside a window.

Optional Feature:
Macro SPIKE_ENC_POISSON_EN.
- Defined:
  - Accumulators are replaced by an 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, loaded with LFSR_SEED on start.
  - The LFSR advances every RUN edge.
  - Channel c compares the LFSR value rotated left by c bits; spike_o[c] <= (rot_lfsr < intensity[c]).
  - I=0 never spikes; counts are stochastic.
- Undefined: deterministic accumulator encoding as described in Behaviour. All other timing and handshakes are identical in both modes.

Test Plan:
1. Assert rst_ni=0 asynchronously mid-cycle -> spike_o=0, busy_o=0, done_o=0, wr_ready_o=1 before the next edge.
2. Write intensities [0,1,64,128,200,255,17,3], pulse start_i, count spike_o per channel -> counts exactly [0,1,64,128,200,255,17,3]; busy_o high 256 cycles; done_o pulses once at the 256th slot; spike_o=0 afterwards.
3. Single channel with I=128 -> slot pattern 0,1,0,1,...; first slot 0; 128 spikes total.
4. Pulse start_i, at slot 10 write wr_data_i=255 to channel 0 -> wr_ready_o=0 and write dropped. At slot 20 assert stop_i -> next cycle IDLE, spike_o=0, no done_o. Restart -> channel 0 count equals its original value.
5. Start with I=200 on all channels, assert rst_ni=0 at slot 100, release, start again -> all counts 0, since intensities were reset.
6. With SPIKE_ENC_POISSON_EN defined and channels at I=0 and I=128 -> channel at I=0 gives 0 spikes; channel at I=128 gives a count within [100,156]; same seed reproduces the identical spike sequence on a second start.

Source files
------------

// File: rtl/spike_rate_encoder.sv
// Rate-codes NUM_CHANNELS stored intensities into spike trains over a WINDOW_LEN-slot window.
// Define SPIKE_ENC_POISSON_EN to replace the phase accumulators with an LFSR-driven Poisson encoder.
module spike_rate_encoder #(
  parameter int          NUM_CHANNELS = 8,
  parameter int          WIDTH_P      = 8,
  parameter int          WINDOW_LEN   = 256,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5,
  localparam int         ADDR_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_en_i,
  input  logic [ADDR_W-1:0]       wr_addr_i,
  input  logic [WIDTH_P-1:0]      wr_data_i,
  output logic                    wr_ready_o,
  input  logic                    start_i,
  input  logic                    stop_i,
  output logic [NUM_CHANNELS-1:0] spike_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int               CNT_W     = $clog2(WINDOW_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WINDOW_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_CHANNELS-1:0] spike_q, spike_d;
  logic                    done_q, done_d;
  logic [WIDTH_P-1:0]      intensity_q [NUM_CHANNELS];
  logic [WIDTH_P-1:0]      intensity_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] enc_spike;
  logic                    wr_ok;

  // Host writes land only outside RUN, so a window always sees a stable intensity set.
  assign wr_ok = wr_en_i && (state_q != ST_RUN) && (32'(wr_addr_i) < NUM_CHANNELS);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    intensity_d = intensity_q;
    if (wr_ok) begin
      intensity_d[wr_addr_i] = wr_data_i;
    end
  end

`ifdef SPIKE_ENC_POISSON_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] lfsr_step;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] dbl;
    dbl = {v, v} << n;
    return dbl[15:8];
  endfunction

  // Galois form of x^8+x^6+x^5+x^4+1, shifting right with tap mask 0xB8.
  always_comb begin
    lfsr_step = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    enc_spike = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      enc_spike[c] = {WIDTH_P'(0), rotl8(lfsr_q, c % 8)} < {8'h00, intensity_q[c]};
    end
  end
`else
  logic [WIDTH_P-1:0] acc_q    [NUM_CHANNELS];
  logic [WIDTH_P-1:0] acc_d    [NUM_CHANNELS];
  logic [WIDTH_P-1:0] acc_next [NUM_CHANNELS];
  logic [WIDTH_P:0]   sum      [NUM_CHANNELS];

  // Each channel carries out of its phase accumulator floor(I*WINDOW_LEN/2^WIDTH_P) times per window.
  always_comb begin
    enc_spike = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      sum[c]       = {1'b0, acc_q[c]} + {1'b0, intensity_q[c]};
      acc_next[c]  = sum[c][WIDTH_P-1:0];
      enc_spike[c] = sum[c][WIDTH_P];
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    spike_d = spike_q;
    done_d  = 1'b0;
`ifdef SPIKE_ENC_POISSON_EN
    lfsr_d  = lfsr_q;
`else
    acc_d   = acc_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        spike_d = '0;
        if (start_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
`ifdef SPIKE_ENC_POISSON_EN
          lfsr_d  = LFSR_SEED;
`else
          acc_d   = '{default: '0};
`endif
        end
      end
      ST_RUN: begin
        // An abort wins over the window's final slot, suppressing done_o.
        if (stop_i) begin
          state_d = ST_IDLE;
          spike_d = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          spike_d = enc_spike;
`ifdef SPIKE_ENC_POISSON_EN
          lfsr_d  = lfsr_step;
`else
          acc_d   = acc_next;
`endif
          if (cnt_q == LAST_SLOT) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      spike_q <= '0;
      done_q  <= 1'b0;
`ifdef SPIKE_ENC_POISSON_EN
      lfsr_q  <= LFSR_SEED;
`endif
      // NOTE: the intensity registers are architectural state that must read 0 after reset, so they are flops with reset rather than RAM.
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        intensity_q[c] <= '0;
`ifndef SPIKE_ENC_POISSON_EN
        acc_q[c]       <= '0;
`endif
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      spike_q     <= spike_d;
      done_q      <= done_d;
      intensity_q <= intensity_d;
`ifdef SPIKE_ENC_POISSON_EN
      lfsr_q      <= lfsr_d;
`else
      acc_q       <= acc_d;
`endif
    end
  end

  assign spike_o    = spike_q;
  assign done_o     = done_q;
  assign busy_o     = (state_q == ST_RUN);
  assign wr_ready_o = (state_q != ST_RUN);

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Randomized self-checking bench for spike_rate_encoder; expected spikes come from the floor-ratio rule.
// Build with SPIKE_ENC_POISSON_EN defined to exercise the stochastic mode instead.
module tb_spike_rate_encoder;

  localparam int NCH = 8;
  localparam int W   = 8;
  localparam int WIN = 256;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           wr_en_i;
  logic [2:0]     wr_addr_i;
  logic [W-1:0]   wr_data_i;
  logic           wr_ready_o;
  logic           start_i;
  logic           stop_i;
  logic [NCH-1:0] spike_o;
  logic           busy_o;
  logic           done_o;

  int checks = 0;
  int errors = 0;
  int model_int [NCH];
  int last_cnt  [NCH];
  logic [NCH-1:0] last_seq [WIN];

  spike_rate_encoder #(
    .NUM_CHANNELS(NCH),
    .WIDTH_P     (W),
    .WINDOW_LEN  (WIN),
    .LFSR_SEED   (8'hA5)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .wr_ready_o(wr_ready_o),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .spike_o   (spike_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slot k of a channel spikes when floor(n*I/2^W) steps up between n=k and n=k+1.
  function automatic logic [NCH-1:0] exp_slot(input int k);
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) begin
      v[c] = (((k + 1) * model_int[c]) >> W) != ((k * model_int[c]) >> W);
    end
    return v;
  endfunction

  task automatic host_write(input int a, input int d);
    check("wr_ready_idle", wr_ready_o, 1);
    wr_en_i   = 1'b1;
    wr_addr_i = 3'(a);
    wr_data_i = 8'(d);
    @(posedge clk_i); #1;
    wr_en_i   = 1'b0;
    model_int[a] = d;
  endtask

  task automatic run_window(input int stop_at, input int wr_at, input int rst_at,
                            input int restart_at, input int sw_addr, input int sw_data);
    int cnt [NCH];
    int busy_n;
    int done_n;
    bit aborted;
    foreach (cnt[c]) cnt[c] = 0;
    if (sw_addr >= 0) begin
      wr_en_i   = 1'b1;
      wr_addr_i = 3'(sw_addr);
      wr_data_i = 8'(sw_data);
      model_int[sw_addr] = sw_data;
    end
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wr_en_i = 1'b0;
    check("start_spike", spike_o, 0);
    check("start_done", done_o, 0);
    busy_n  = busy_o ? 1 : 0;
    done_n  = 0;
    aborted = 1'b0;
    for (int k = 0; k < WIN; k++) begin
      @(posedge clk_i); #1;
      wr_en_i = 1'b0;
      start_i = 1'b0;
      last_seq[k] = spike_o;
`ifndef SPIKE_ENC_POISSON_EN
      check($sformatf("slot%0d", k), spike_o, exp_slot(k));
`endif
      for (int c = 0; c < NCH; c++) cnt[c] += int'(spike_o[c]);
      if (busy_o) busy_n++;
      if (done_o) done_n++;
      if (k == wr_at) begin
        check("run_wr_ready", wr_ready_o, 0);
        wr_en_i   = 1'b1;
        wr_addr_i = 3'd0;
        wr_data_i = 8'hFF;
      end
      if (k == restart_at) start_i = 1'b1;
      if (k == stop_at) begin
        stop_i = 1'b1;
        @(posedge clk_i); #1;
        stop_i  = 1'b0;
        wr_en_i = 1'b0;
        start_i = 1'b0;
        check("stop_busy", busy_o, 0);
        check("stop_spike", spike_o, 0);
        check("stop_done", done_o, 0);
        check("stop_wr_ready", wr_ready_o, 1);
        aborted = 1'b1;
        break;
      end
      if (k == rst_at) begin
        #2 rst_ni = 1'b0;
        #1;
        check("rst_spike", spike_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_wr_ready", wr_ready_o, 1);
        foreach (model_int[c]) model_int[c] = 0;
        #2 rst_ni = 1'b1;
        wr_en_i = 1'b0;
        start_i = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      check("abort_no_done", done_n, 0);
    end else begin
      check("busy_cycles", busy_n, WIN);
      check("done_pulses", done_n, 1);
      @(posedge clk_i); #1;
      check("post_spike", spike_o, 0);
      check("post_done", done_o, 0);
      check("post_busy", busy_o, 0);
      check("post_wr_ready", wr_ready_o, 1);
`ifndef SPIKE_ENC_POISSON_EN
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("count_ch%0d", c), cnt[c], (model_int[c] * WIN) >> W);
      end
`endif
    end
    last_cnt = cnt;
  endtask

  initial begin
    int vals [NCH] = '{0, 1, 64, 128, 200, 255, 17, 3};
    rst_ni    = 1'b0;
    wr_en_i   = 1'b0;
    wr_addr_i = '0;
    wr_data_i = '0;
    start_i   = 1'b0;
    stop_i    = 1'b0;
    foreach (model_int[c]) model_int[c] = 0;

    #12;
    check("reset_spike", spike_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_wr_ready", wr_ready_o, 1);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

`ifndef SPIKE_ENC_POISSON_EN
    for (int c = 0; c < NCH; c++) host_write(c, vals[c]);
    run_window(-1, -1, -1, -1, -1, 0);

    // Single channel at half scale, written in the same cycle as start.
    for (int c = 0; c < NCH; c++) host_write(c, 0);
    run_window(-1, -1, -1, -1, 2, 128);

    // Dropped mid-run write, ignored re-start, abort, then a clean restart.
    for (int c = 0; c < NCH; c++) host_write(c, int'($urandom_range(0, 255)));
    run_window(20, 10, -1, 5, -1, 0);
    run_window(-1, -1, -1, -1, -1, 0);

    // Abort on the very edge that would have completed the window.
    run_window(WIN - 2, -1, -1, -1, -1, 0);

    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < NCH; c++) host_write(c, int'($urandom_range(0, 255)));
      host_write(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 255)));
      run_window(-1, -1, -1, -1, (r == 1) ? int'($urandom_range(0, NCH - 1)) : -1,
                 int'($urandom_range(0, 255)));
    end

    // Reset mid-window wipes the intensities.
    for (int c = 0; c < NCH; c++) host_write(c, 200);
    run_window(-1, -1, 100, -1, -1, 0);
    @(posedge clk_i); #1;
    run_window(-1, -1, -1, -1, -1, 0);
`else
    begin
      logic [NCH-1:0] first_seq [WIN];
      int c1;
      host_write(0, 0);
      host_write(1, 128);
      for (int c = 2; c < NCH; c++) host_write(c, int'($urandom_range(0, 255)));
      run_window(-1, -1, -1, -1, -1, 0);
      c1 = last_cnt[1];
      first_seq = last_seq;
      check("poisson_zero", last_cnt[0], 0);
      check("poisson_half_range", (c1 >= 100 && c1 <= 156) ? 1 : 0, 1);
      run_window(-1, -1, -1, -1, -1, 0);
      check("poisson_repeat_cnt", last_cnt[1], c1);
      for (int k = 0; k < WIN; k++) begin
        check($sformatf("poisson_seq%0d", k), last_seq[k], first_seq[k]);
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
